// File: rtl/exec_pipe.sv
// Handshaked execute stage: rhs = (X op O) + A, with a multi-cycle multiply.
// Optional macro EXEC_PIPE_SRA_EN turns reserved op 0100 into an arithmetic shift right.
module exec_pipe #(
  parameter int WIDTH      = 32,
  parameter int MUL_STAGES = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             swap,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [WIDTH-1:0] I,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] rhs,
  output logic             out_err
);

  localparam int CW = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;
  localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rhs_q, rhs_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] mx_q, mx_d;
  logic [WIDTH-1:0] mo_q, mo_d;
  logic [WIDTH-1:0] ma_q, ma_d;

  logic [WIDTH-1:0] opo, opa;
  logic [WIDTH-1:0] alu_raw, alu_res, mul_res;
  logic             alu_err;
  logic             is_mul, acc;

  assign opo = swap ? I : Y;
  assign opa = swap ? Y : I;

  always_comb begin
    alu_raw = '0;
    alu_err = 1'b0;
    case (op)
      4'b0000: alu_raw = X | opo;
      4'b0001: alu_raw = X & opo;
      4'b0010: alu_raw = X + opo;
      // Only the single-cycle build multiplies here; otherwise the MUL state owns it.
      4'b0011: if (MUL_STAGES == 1) alu_raw = X * opo;
      4'b0101: alu_raw = (opo >= W_LIM) ? '0 : (X << opo);
      4'b0110: alu_raw = {WIDTH{$signed(X) < $signed(opo)}};
      4'b0111: alu_raw = {WIDTH{X == opo}};
      4'b1000: alu_raw = {WIDTH{$signed(X) > $signed(opo)}};
      4'b1001: alu_raw = X & ~opo;
      4'b1010: alu_raw = X ^ opo;
      4'b1011: alu_raw = X - opo;
      4'b1100: alu_raw = ~(X ^ opo);
      4'b1101: alu_raw = (opo >= W_LIM) ? '0 : (X >> opo);
      4'b1110: alu_raw = {WIDTH{X != opo}};
`ifdef EXEC_PIPE_SRA_EN
      4'b0100: alu_raw = (opo >= W_LIM) ? {WIDTH{X[WIDTH-1]}} : ($signed(X) >>> opo);
`else
      4'b0100: alu_err = 1'b1;
`endif
      default: alu_err = 1'b1;
    endcase
  end

  assign alu_res  = alu_err ? '0 : (alu_raw + opa);
  assign mul_res  = (mx_q * mo_q) + ma_q;
  assign is_mul   = (op == 4'b0011);
  assign in_ready = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign acc      = in_valid & in_ready & ~flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rhs_d   = rhs_q;
    err_d   = err_q;
    mx_d    = mx_q;
    mo_d    = mo_q;
    ma_d    = ma_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if ((state_q == DONE) && out_ready) state_d = IDLE;
          if (acc) begin
            if (is_mul && (MUL_STAGES > 1)) begin
              state_d = MUL;
              cnt_d   = CW'(MUL_STAGES - 1);
              mx_d    = X;
              mo_d    = opo;
              ma_d    = opa;
            end else begin
              state_d = DONE;
              rhs_d   = alu_res;
              err_d   = alu_err;
            end
          end
        end
        MUL: begin
          if (cnt_q == CW'(1)) begin
            state_d = DONE;
            cnt_d   = '0;
            rhs_d   = mul_res;
            err_d   = 1'b0;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rhs_q   <= '0;
      err_q   <= 1'b0;
      mx_q    <= '0;
      mo_q    <= '0;
      ma_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rhs_q   <= rhs_d;
      err_q   <= err_d;
      mx_q    <= mx_d;
      mo_q    <= mo_d;
      ma_q    <= ma_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign rhs       = rhs_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_exec_pipe.sv
// Bench for exec_pipe (WIDTH=32, MUL_STAGES=3): vector table, directed corner sequences,
// and randomized traffic scored against a behavioural reference.
module tb_exec_pipe;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic        swap;
  logic [31:0] X, Y, I;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] rhs;
  logic        out_err;

  int total = 0;
  int bad   = 0;

  exec_pipe #(.WIDTH(32), .MUL_STAGES(3)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .swap(swap), .X(X), .Y(Y), .I(I),
    .out_valid(out_valid), .out_ready(out_ready),
    .rhs(rhs), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic        sw;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] i;
    logic [31:0] exp_rhs;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];
  logic [32:0] sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] o, input logic s, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] i);
    op = o; swap = s; X = x; Y = y; I = i; in_valid = 1'b1;
  endtask

  // Reference: returns {err, rhs} from the arithmetic rules, independent of timing.
  function automatic logic [32:0] ref_calc(input logic [3:0] o_code, input logic s,
                                           input logic [31:0] x, input logic [31:0] y,
                                           input logic [31:0] i);
    logic [31:0] o, a, r;
    longint unsigned prod;
    o = s ? i : y;
    a = s ? y : i;
    r = 32'd0;
    case (o_code)
      4'h0: r = x | o;
      4'h1: r = x & o;
      4'h2: r = x + o;
      4'h3: begin prod = longint'(x) * longint'(o); r = prod[31:0]; end
      4'h5: r = (o >= 32) ? 32'd0 : (x << o);
      4'h6: r = ($signed(x) < $signed(o)) ? 32'hFFFFFFFF : 32'd0;
      4'h7: r = (x == o) ? 32'hFFFFFFFF : 32'd0;
      4'h8: r = ($signed(x) > $signed(o)) ? 32'hFFFFFFFF : 32'd0;
      4'h9: r = x & ~o;
      4'hA: r = x ^ o;
      4'hB: r = x - o;
      4'hC: r = ~(x ^ o);
      4'hD: r = (o >= 32) ? 32'd0 : (x >> o);
      4'hE: r = (x != o) ? 32'hFFFFFFFF : 32'd0;
`ifdef EXEC_PIPE_SRA_EN
      4'h4: begin
        if (o >= 32) r = x[31] ? 32'hFFFFFFFF : 32'd0;
        else         r = (x >> o) | (x[31] ? ~(32'hFFFFFFFF >> o) : 32'd0);
      end
`else
      4'h4: return {1'b1, 32'd0};
`endif
      default: return {1'b1, 32'd0};
    endcase
    return {1'b0, r + a};
  endfunction

  initial begin
    vecs[0]  = '{4'h2, 1'b0, 32'd5,        32'd7,        32'hFFFFFFFF, 32'h0000000B, 1'b0};
    vecs[1]  = '{4'h6, 1'b0, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 1'b0};
    vecs[2]  = '{4'h6, 1'b1, 32'hFFFFFFFF, 32'd0,        32'd1,        32'hFFFFFFFF, 1'b0};
    vecs[3]  = '{4'h5, 1'b0, 32'h00001234, 32'd32,       32'd2,        32'd2,        1'b0};
    vecs[4]  = '{4'hD, 1'b0, 32'hDEADBEEF, 32'd40,       32'd2,        32'd2,        1'b0};
`ifdef EXEC_PIPE_SRA_EN
    vecs[5]  = '{4'h4, 1'b0, 32'h80000000, 32'd4,        32'd0,        32'hF8000000, 1'b0};
`else
    vecs[5]  = '{4'h4, 1'b0, 32'h80000000, 32'd4,        32'd0,        32'd0,        1'b1};
`endif
    vecs[6]  = '{4'hF, 1'b0, 32'd1,        32'd2,        32'd3,        32'd0,        1'b1};
    vecs[7]  = '{4'h7, 1'b0, 32'd9,        32'd9,        32'd1,        32'd0,        1'b0};
    vecs[8]  = '{4'hB, 1'b0, 32'd3,        32'd5,        32'd0,        32'hFFFFFFFE, 1'b0};
    vecs[9]  = '{4'h8, 1'b0, 32'd1,        32'hFFFFFFFF, 32'd0,        32'hFFFFFFFF, 1'b0};
    vecs[10] = '{4'hE, 1'b0, 32'd1,        32'd1,        32'd7,        32'd7,        1'b0};
    vecs[11] = '{4'h9, 1'b0, 32'h000000FF, 32'h0000000F, 32'd0,        32'h000000F0, 1'b0};
    vecs[12] = '{4'hC, 1'b0, 32'd0,        32'd0,        32'd1,        32'd0,        1'b0};
    vecs[13] = '{4'h5, 1'b1, 32'h00000003, 32'd1,        32'd4,        32'd49,       1'b0};

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'h0; swap = 1'b0; X = '0; Y = '0; I = '0;
    tick(); tick();
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_rhs", rhs, 32'd0);
    chk("reset_out_err", {31'd0, out_err}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    reset_n = 1'b1;
    tick();

    // Table: one latency-1 transaction each, then drain to IDLE.
    out_ready = 1'b1;
    for (int k = 0; k < 14; k++) begin
      drive(vecs[k].op, vecs[k].sw, vecs[k].x, vecs[k].y, vecs[k].i);
      tick();
      in_valid = 1'b0;
      chk($sformatf("vec%0d_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_rhs", k), rhs, vecs[k].exp_rhs);
      chk($sformatf("vec%0d_err", k), {31'd0, out_err}, {31'd0, vecs[k].exp_err});
      tick();
      chk($sformatf("vec%0d_drain", k), {31'd0, out_valid}, 32'd0);
    end

    // Multiply latency, then back-to-back accept in the DONE cycle.
    drive(4'h3, 1'b0, 32'h00010000, 32'h00010000, 32'd3);
    tick();
    in_valid = 1'b0;
    chk("mul_c1_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mul_c1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("mul_c2_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mul_c2_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("mul_done_valid", {31'd0, out_valid}, 32'd1);
    chk("mul_done_rhs", rhs, 32'd3);
    chk("mul_done_err", {31'd0, out_err}, 32'd0);
    chk("mul_done_in_ready", {31'd0, in_ready}, 32'd1);
    drive(4'h2, 1'b0, 32'd1, 32'd2, 32'd10);
    tick();
    in_valid = 1'b0;
    chk("b2b_valid", {31'd0, out_valid}, 32'd1);
    chk("b2b_rhs", rhs, 32'd13);
    tick();

    // Backpressure hold, then consume and accept on the same edge.
    out_ready = 1'b0;
    drive(4'h0, 1'b0, 32'h000000F0, 32'h0000000F, 32'd0);
    tick();
    drive(4'hA, 1'b0, 32'h000000FF, 32'h0000000F, 32'd0);
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("hold%0d_rhs", c), rhs, 32'h000000FF);
      chk($sformatf("hold%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
      chk($sformatf("hold%0d_valid", c), {31'd0, out_valid}, 32'd1);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("release_valid", {31'd0, out_valid}, 32'd1);
    chk("release_rhs", rhs, 32'h000000F0);
    tick();

    // Flush at counter==1 kills the multiply.
    drive(4'h3, 1'b0, 32'd3, 32'd4, 32'd0);
    tick();
    in_valid = 1'b0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    tick(); tick();
    chk("flush_stays_idle", {31'd0, out_valid}, 32'd0);

    // Flush beats a simultaneous acceptance.
    drive(4'h2, 1'b0, 32'd1, 32'd1, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_vs_accept", {31'd0, out_valid}, 32'd0);
    tick();
    chk("flush_vs_accept_later", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-multiply clears outputs before any edge.
    drive(4'h2, 1'b0, 32'd5, 32'd5, 32'd0);
    tick();
    in_valid = 1'b0;
    chk("pre_reset_rhs", rhs, 32'h0000000A);
    tick();
    drive(4'h3, 1'b0, 32'd6, 32'd7, 32'd0);
    tick();
    in_valid = 1'b0;
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_rhs", rhs, 32'd0);
    chk("async_rst_err", {31'd0, out_err}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Randomized traffic with backpressure against the reference scoreboard.
    for (int n = 0; n < 600; n++) begin
      logic [3:0]  r_op;
      logic [31:0] r_y;
      r_op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r_op = 4'h3;
      r_y = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 40)) : $urandom;
      op = r_op;
      swap = 1'($urandom_range(0, 1));
      X = $urandom;
      Y = r_y;
      I = swap ? 32'($urandom_range(0, 40)) : $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      #3;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("rand_unexpected_out", 32'd1, 32'd0);
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          chk("rand_rhs", rhs, e[31:0]);
          chk("rand_err", {31'd0, out_err}, {31'd0, e[32]});
        end
      end
      if (in_valid && in_ready) sb.push_back(ref_calc(op, swap, X, Y, I));
      tick();
    end

    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #3;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("drain_unexpected_out", 32'd1, 32'd0);
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          chk("drain_rhs", rhs, e[31:0]);
          chk("drain_err", {31'd0, out_err}, {31'd0, e[32]});
        end
      end
      tick();
    end
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/exec_pipe.md
Name: exec_pipe

Overview:
- Parametrised, handshaked successor to the core's single-cycle execute stage. Evaluates `rhs = (X op O) + A` with the existing 4-bit op encoding and operand swap. O/A are Y/I, or I/Y when `swap` is set.
- Operand width is generic. Multiply is multi-cycle with a configurable latency.
- Sits between decode/register-read and the memory/commit stages. Lets a future pipelined core stall on either side via valid/ready.

Parameters:
- WIDTH, 32, operand and result width in bits (>= 8).
- MUL_STAGES, 3, cycles from input acceptance to `out_valid` for op 0011 (>= 1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  reset, asynchronous, active-low.
- flush  input  1  synchronous abort of any in-flight operation.
- in_valid  input  1  operands and op present.
- in_ready  output  1  block accepts the input this cycle.
- op  input  4  operation code (core encoding).
- swap  input  1  1 selects O=I, A=Y; 0 selects O=Y, A=I.
- X  input  WIDTH  left operand, signed for compares.
- Y  input  WIDTH  register operand.
- I  input  WIDTH  immediate, already sign-extended by the caller.
- out_valid  output  1  result present.
- out_ready  input  1  consumer takes the result this cycle.
- rhs  output  WIDTH  result.
- out_err  output  1  result came from a reserved op; qualified by `out_valid`.

Behaviour:
- States:
  - IDLE: empty.
  - MUL: multiply counting.
  - DONE: result held.
- Reset (async, reset_n=0): state IDLE, out_valid=0, rhs=0, out_err=0, counter=0. Any in-flight operation is discarded. Recovery is synchronous to clk.
- in_ready = (state==IDLE) | (state==DONE & out_ready). It is combinational and never depends on in_valid.
- out_valid = (state==DONE).
- Acceptance (in_valid & in_ready at an edge) latches op, X, O, A.
  - Non-multiply ops: result registered on the same edge, state -> DONE. Latency 1.
  - Multiply with MUL_STAGES==1: same as non-multiply.
  - Multiply with MUL_STAGES>1: state -> MUL, counter = MUL_STAGES-1. Each edge in MUL decrements the counter. At counter==1 the result is written and state -> DONE. out_valid rises exactly MUL_STAGES edges after acceptance.
- DONE:
  - out_ready=1, no new input: -> IDLE.
  - out_ready=1 with acceptance: next result loaded back-to-back with no bubble.
  - out_ready=0: rhs and out_err held stable.
- Arithmetic (all WIDTH bits, wrap modulo 2^WIDTH):
  - 0000 or, 0001 and, 0010 add, 0011 multiply (low WIDTH bits of product), 0101 shift left, 0110 signed <, 0111 ==, 1000 signed >, 1001 and-not, 1010 xor, 1011 subtract, 1100 xnor, 1101 logical shift right, 1110 !=.
  - Each result then has A added.
  - Compares yield all-ones (true) or zero (false) before adding A.
  - Shifts use O as unsigned. Any amount >= WIDTH gives 0 before adding A.
- Reserved ops 0100 and 1111: rhs = 0, out_err = 1, latency 1. out_err = 0 for every other op.
- flush=1 at an edge: state -> IDLE, out_valid drops, the held result is lost, and no input is accepted that edge. in_ready remains as defined. flush wins over simultaneous acceptance or completion.
- rhs is not cleared on leaving DONE; it is only meaningful while out_valid=1.

Optional Feature:
- Macro EXEC_PIPE_SRA_EN.
- Defined: op 0100 is an arithmetic shift right of signed X by O, plus A. Amounts >= WIDTH give all sign bits. out_err=0, latency 1.
- Undefined: op 0100 is reserved, as above. No sign-extending shifter is synthesised.

Test Plan:
- WIDTH=32, op 0010, swap=0, X=5, Y=7, I=0xFFFFFFFF: accepted at edge 0 -> out_valid after edge 1, rhs=0x0000000B, out_err=0.
- Op 0011, MUL_STAGES=3, X=0x10000, Y=0x10000, I=3, out_ready=1: in_ready=0 for 2 cycles, out_valid 3 edges after acceptance, rhs=0x00000003. Back-to-back accept in the DONE cycle.
- Op 0110, X=0xFFFFFFFF, Y=1, I=0, swap=0 -> rhs=0xFFFFFFFF. Same with swap=1, Y=0, I=1 (O=1, A=0) -> rhs=0xFFFFFFFF.
- Op 0101 with O=32 and op 1101 with O=40, A=2 -> rhs=2 for both. With EXEC_PIPE_SRA_EN, op 0100, X=0x80000000, O=4, A=0 -> 0xF8000000. Without the macro -> rhs=0, out_err=1.
- Hold out_ready=0 for 4 cycles with a result in DONE: rhs stable and in_ready=0. Then raise out_ready with in_valid=1: result consumed and the new op accepted on the same edge.
- Multiply in MUL: assert flush at counter==1 -> IDLE, no out_valid. Repeat, but drop reset_n mid-MUL -> out_valid=0 and rhs=0 immediately, before the next clk edge.
